// File: rtl/state_receiver.sv
// Receive side of the inter-board player-state serial link: synchronizes the
// three-wire link into clk_pixel_in and reassembles one frame. Option macro: RX_PARITY_EN.
`timescale 1ns/1ps
module state_receiver #(
  parameter int DATA_WIDTH     = 89,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  frame_error_out,
  output logic                  busy_out
);

`ifdef RX_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  localparam int CNT_MAX = DATA_WIDTH + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_RECEIVE,
    S_CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_dclk_sync;
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_dclk_prev;
  logic                   r_sel_prev;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_count;
  logic [TO_W-1:0]        r_timeout;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic                   r_valid;
  logic                   r_error;
`ifdef RX_PARITY_EN
  logic                   r_parity;
`endif

  logic w_data_s, w_dclk_s, w_sel_s;
  logic w_strobe, w_sel_rise, w_sel_fall;
  logic w_timeout, w_frame_ok;
  logic w_busy, w_valid_next, w_error_next;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops update together at the edge regardless of statement order.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_data_sync <= '0;
      r_dclk_sync <= '0;
      r_sel_sync  <= '1;
      r_warm      <= '0;
      r_dclk_prev <= 1'b0;
      r_sel_prev  <= 1'b1;
    end else begin
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_in};
      r_dclk_sync <= {r_dclk_sync[SYNC_STAGES-2:0], data_clk_in};
      r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], sel_in};
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_dclk_prev <= w_dclk_s;
      r_sel_prev  <= w_sel_s;
    end
  end

  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_dclk_s   = r_dclk_sync[SYNC_STAGES-1];
  assign w_sel_s    = r_sel_sync[SYNC_STAGES-1];
  assign w_strobe   = w_dclk_s & ~r_dclk_prev;
  assign w_sel_rise = w_sel_s & ~r_sel_prev;
  assign w_sel_fall = ~w_sel_s & r_sel_prev;
  assign w_timeout  = !w_strobe && (r_timeout == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef RX_PARITY_EN
  assign w_frame_ok = (r_count == CNT_W'(FRAME_LEN)) && ((^r_shift ^ r_parity) == 1'b0);
`else
  assign w_frame_ok = (r_count == CNT_W'(FRAME_LEN));
`endif

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) r_state <= S_WAIT_IDLE;
    else        r_state <= w_state_next;
  end

  // The sel synchronizer resets high, so leaving WAIT_IDLE is held off until
  // the chain has been refilled with post-reset samples of the pin.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    case (r_state)
      S_WAIT_IDLE: if (r_warm[SYNC_STAGES-1] && w_sel_s) w_state_next = S_IDLE;
      S_IDLE:      if (w_sel_fall)                        w_state_next = S_RECEIVE;
      S_RECEIVE: begin
        if (w_sel_rise)     w_state_next = S_CHECK;
        else if (w_timeout) w_state_next = S_WAIT_IDLE;
      end
      S_CHECK:     w_state_next = S_IDLE;
      default:     w_state_next = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = 1'b0;
    w_valid_next = 1'b0;
    w_error_next = 1'b0;
    case (r_state)
      S_RECEIVE: begin
        w_busy       = 1'b1;
        w_error_next = w_timeout && !w_sel_rise;
      end
      S_CHECK: begin
        w_valid_next = w_frame_ok;
        w_error_next = !w_frame_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_count    <= '0;
      r_timeout  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
`ifdef RX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_valid <= w_valid_next;
      r_error <= w_error_next;
      if (w_valid_next) r_data_out <= r_shift;

      if (r_state == S_IDLE && w_sel_fall) begin
        r_count   <= '0;
        r_timeout <= '0;
        r_shift   <= '0;
`ifdef RX_PARITY_EN
        r_parity  <= 1'b0;
`endif
      end else if (r_state == S_RECEIVE) begin
        if (w_strobe) begin
          // With parity the newest bit waits in r_parity, so the shift
          // register ends up holding exactly the payload.
`ifdef RX_PARITY_EN
          r_parity <= w_data_s;
          r_shift  <= {r_shift[DATA_WIDTH-2:0], r_parity};
`else
          r_shift  <= {r_shift[DATA_WIDTH-2:0], w_data_s};
`endif
          if (r_count != CNT_W'(CNT_MAX)) r_count <= r_count + CNT_W'(1);
          r_timeout <= '0;
        end else begin
          r_timeout <= r_timeout + TO_W'(1);
        end
      end
    end
  end

  assign data_out        = r_data_out;
  assign data_out_valid  = r_valid;
  assign frame_error_out = r_error;
  assign busy_out        = w_busy;

endmodule
